dmac_top: RTL and testbench

DMAC_TOP -- requirements
Module: dmac_top

---
 rtl/dmac_if.sv | 26 ++
 rtl/dmac_top.sv | 197 +++++++++++++++++++
 tb/tb_dmac_top.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_if.sv
// Bus bundle for the DMA controller: a bus-master port toward memory
// and a register-slave port toward the host.
interface dmac_if;
   logic        m_grant;
   logic [31:0] m_din;
   logic        m_req;
   logic        m_wr;
   logic [15:0] m_address;
   logic [31:0] m_dout;
   logic        s_sel;
   logic        s_wr;
   logic [15:0] s_address;
   logic [31:0] s_din;
   logic [31:0] s_dout;
   logic        s_interrupt;

   modport master (
      input  m_grant, m_din,
      output m_req, m_wr, m_address, m_dout
   );

   modport slave (
      input  s_sel, s_wr, s_address, s_din,
      output s_dout, s_interrupt
   );
endinterface

// File: rtl/dmac_top.sv
// Descriptor-driven DMA controller: 16-entry descriptor FIFO feeding a
// word-by-word read/write copy engine on a request/grant master bus.
module dmac_top (
   input  logic   clk,
   input  logic   reset_n,
   dmac_if.master m_bus,
   dmac_if.slave  s_bus
);
   typedef enum logic [2:0] {
      IDLE, LOAD, READ, WRITE, DONE
   } state_t;

   localparam logic [15:0] A_START = 16'h0000;
   localparam logic [15:0] A_IRQ   = 16'h0001;
   localparam logic [15:0] A_IEN   = 16'h0002;
   localparam logic [15:0] A_SRC   = 16'h0003;
   localparam logic [15:0] A_DST   = 16'h0004;
   localparam logic [15:0] A_SIZE  = 16'h0005;
   localparam logic [15:0] A_PUSH  = 16'h0006;
   localparam logic [15:0] A_MODE  = 16'h0008;
   localparam logic [15:0] A_STAT  = 16'h0009;

   state_t      state_q;
   logic        start_q;
   logic        irq_q;
   logic        irq_en_q;
   logic        mode_q;
   logic [15:0] src_stg_q;
   logic [15:0] dst_stg_q;
   logic [15:0] size_stg_q;

   logic [47:0] fifo_q [16];
   logic [3:0]  wr_ptr_q;
   logic [3:0]  rd_ptr_q;
   logic [4:0]  cnt_q;
   logic [4:0]  cnt_d;

   logic [15:0] src_q;
   logic [15:0] dst_q;
   logic [15:0] count_q;
   logic [31:0] buf_q;
   logic        m_req_q;
   logic        m_wr_q;
   logic [15:0] m_addr_q;

   logic        wr_en;
   logic        rd_en;
   logic        full;
   logic        empty;
   logic        busy;
   logic        push;
   logic        pop;
   logic [47:0] head;
   logic [15:0] count_dec;
   logic [15:0] src_inc;
   logic [15:0] dst_inc;
   logic [31:0] rdata;

   always_comb begin
      wr_en     = s_bus.s_sel & s_bus.s_wr;
      rd_en     = s_bus.s_sel & ~s_bus.s_wr;
      full      = (cnt_q == 5'd16);
      empty     = (cnt_q == 5'd0);
      busy      = (state_q != IDLE);
      push      = wr_en && (s_bus.s_address == A_PUSH)
                  && s_bus.s_din[0] && !full;
      pop       = (state_q == LOAD) && !empty;
      cnt_d     = cnt_q + {4'b0, push} - {4'b0, pop};
      head      = fifo_q[rd_ptr_q];
      count_dec = count_q - 16'd1;
      src_inc   = src_q + 16'd4;
      dst_inc   = dst_q + 16'd4;
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         irq_q      <= 1'b0;
         irq_en_q   <= 1'b0;
         mode_q     <= 1'b0;
         src_stg_q  <= '0;
         dst_stg_q  <= '0;
         size_stg_q <= '0;
         for (int i = 0; i < 16; i++) fifo_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         count_q    <= '0;
         buf_q      <= '0;
         m_req_q    <= 1'b0;
         m_wr_q     <= 1'b0;
         m_addr_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= {src_stg_q, dst_stg_q, size_stg_q};
            wr_ptr_q         <= wr_ptr_q + 4'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 4'd1;

         if (wr_en) begin
            case (s_bus.s_address)
               A_IRQ:   irq_q      <= s_bus.s_din[0];
               A_IEN:   irq_en_q   <= s_bus.s_din[0];
               A_SRC:   src_stg_q  <= s_bus.s_din[15:0];
               A_DST:   dst_stg_q  <= s_bus.s_din[15:0];
               A_SIZE:  size_stg_q <= s_bus.s_din[15:0];
               A_MODE:  mode_q     <= s_bus.s_din[0];
               default: ;
            endcase
         end

         // DONE is handled after the host write so its set wins a clear
         unique case (state_q)
            IDLE: begin
               if (wr_en && (s_bus.s_address == A_START)
                   && s_bus.s_din[0]) begin
                  start_q <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               if (empty) begin
                  state_q <= DONE;
               end else begin
                  src_q   <= head[47:32];
                  dst_q   <= head[31:16];
                  count_q <= head[15:0];
                  if (head[15:0] != 16'd0) begin
                     m_req_q  <= 1'b1;
                     m_wr_q   <= 1'b0;
                     m_addr_q <= head[47:32];
                     state_q  <= READ;
                  end
               end
            end
            READ: begin
               if (m_bus.m_grant) begin
                  buf_q    <= m_bus.m_din;
                  m_wr_q   <= 1'b1;
                  m_addr_q <= dst_q;
                  state_q  <= WRITE;
               end
            end
            WRITE: begin
               if (m_bus.m_grant) begin
                  count_q <= count_dec;
                  m_wr_q  <= 1'b0;
                  if (!mode_q) begin
                     src_q <= src_inc;
                     dst_q <= dst_inc;
                  end
                  if (count_dec == 16'd0) begin
                     m_req_q <= 1'b0;
                     state_q <= LOAD;
                  end else begin
                     m_addr_q <= mode_q ? src_q : src_inc;
                     state_q  <= READ;
                  end
               end
            end
            DONE: begin
               irq_q   <= 1'b1;
               start_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (s_bus.s_address)
         A_START: rdata = {31'b0, start_q};
         A_IRQ:   rdata = {31'b0, irq_q};
         A_IEN:   rdata = {31'b0, irq_en_q};
         A_SRC:   rdata = {16'b0, src_stg_q};
         A_DST:   rdata = {16'b0, dst_stg_q};
         A_SIZE:  rdata = {16'b0, size_stg_q};
         A_PUSH:  rdata = {27'b0, cnt_q};
         A_MODE:  rdata = {31'b0, mode_q};
         A_STAT:  rdata = {29'b0, empty, full, busy};
         default: rdata = '0;
      endcase
      s_bus.s_dout      = rd_en ? rdata : 32'd0;
      s_bus.s_interrupt = irq_q & irq_en_q;
   end

   assign m_bus.m_req     = m_req_q;
   assign m_bus.m_wr      = m_wr_q;
   assign m_bus.m_address = m_addr_q;
   assign m_bus.m_dout    = buf_q;
endmodule

// File: tb/tb_dmac_top.sv
// Directed bench for dmac_top: expected bus transfers and register reads
// are queued by the stimulus and checked by a negedge monitor.
module tb_dmac_top;
   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] data;
   } bus_t;

   logic clk = 1'b0;
   logic reset_n;
   logic din_fix;
   int   checks = 0;
   int   errors = 0;

   bus_t        bus_q [$];
   logic [31:0] rd_q  [$];
   string       tag_q [$];

   dmac_if bus ();

   dmac_top dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m_bus   (bus),
      .s_bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory model: fixed word or an address-tagged word
   always_comb begin
      bus.m_din = din_fix ? 32'h1234_5678 : {16'hD000, bus.m_address};
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bus_t e;
      if (bus.m_req === 1'b1 && bus.m_grant === 1'b1) begin
         if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got wr=%b addr=%h expected none",
                     bus.m_wr, bus.m_address);
         end else begin
            e = bus_q.pop_front();
            chk("bus_wr", {31'b0, bus.m_wr}, {31'b0, e.wr});
            chk("bus_addr", {16'b0, bus.m_address}, {16'b0, e.addr});
            if (e.wr) chk("bus_data", bus.m_dout, e.data);
         end
      end
      if (bus.s_sel === 1'b1 && bus.s_wr === 1'b0) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %h expected none", bus.s_dout);
         end else begin
            chk(tag_q.pop_front(), bus.s_dout, rd_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      bus.s_sel     = 1'b1;
      bus.s_wr      = 1'b1;
      bus.s_address = a;
      bus.s_din     = d;
      tick();
      bus.s_sel = 1'b0;
      bus.s_wr  = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [31:0] e,
                     input string tag);
      bus.s_sel     = 1'b1;
      bus.s_wr      = 1'b0;
      bus.s_address = a;
      rd_q.push_back(e);
      tag_q.push_back(tag);
      tick();
      bus.s_sel = 1'b0;
   endtask

   task automatic desc(input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] n);
      wr(16'h3, {16'b0, s});
      wr(16'h4, {16'b0, d});
      wr(16'h5, {16'b0, n});
      wr(16'h6, 32'd1);
   endtask

   task automatic exp_pair(input logic [15:0] s, input logic [15:0] d,
                           input logic [31:0] data);
      bus_q.push_back('{wr: 1'b0, addr: s, data: 32'd0});
      bus_q.push_back('{wr: 1'b1, addr: d, data: data});
   endtask

   task automatic wait_irq(input string name, input int budget);
      int n = 0;
      @(negedge clk);
      while (n < budget && bus.s_interrupt !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_irq"}, {31'b0, bus.s_interrupt}, 32'd1);
      chk({name, "_drained"}, bus_q.size(), 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      reset_n       = 1'b1;
      din_fix       = 1'b1;
      bus.m_grant   = 1'b0;
      bus.s_sel     = 1'b0;
      bus.s_wr      = 1'b0;
      bus.s_address = '0;
      bus.s_din     = '0;
      tick();
      tick();
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_req", {31'b0, bus.m_req}, 32'd0);
      chk("rst_wr", {31'b0, bus.m_wr}, 32'd0);
      chk("rst_addr", {16'b0, bus.m_address}, 32'd0);
      chk("rst_dout", bus.m_dout, 32'd0);
      chk("rst_sdout", bus.s_dout, 32'd0);
      chk("rst_int", {31'b0, bus.s_interrupt}, 32'd0);
      tick();
      rd(16'h9, 32'h4, "rst_status");
      rd(16'h7, 32'h0, "unmapped");

      // Single descriptor
      bus.m_grant = 1'b1;
      wr(16'h2, 32'd1);
      desc(16'h0200, 16'h0300, 16'd1);
      rd(16'h6, 32'd1, "s1_count");
      rd(16'h9, 32'h0, "s1_status_pre");
      exp_pair(16'h0200, 16'h0300, 32'h1234_5678);
      wr(16'h0, 32'd1);
      rd(16'h0, 32'd1, "s1_start");
      rd(16'h9, 32'h5, "s1_status_busy");
      wait_irq("s1", 50);
      rd(16'h1, 32'd1, "s1_irq_reg");
      rd(16'h9, 32'h4, "s1_status_done");
      rd(16'h0, 32'd0, "s1_start_clr");
      wr(16'h1, 32'd0);
      @(negedge clk);
      chk("s1_int_drop", {31'b0, bus.s_interrupt}, 32'd0);
      tick();

      // Sixteen descriptors plus an ignored 17th push
      din_fix = 1'b0;
      for (int k = 0; k < 16; k++) begin
         desc(16'h0200 + 16'(4 * k), 16'h0300 + 16'(4 * k), 16'd1);
      end
      rd(16'h9, 32'h2, "s2_full");
      rd(16'h6, 32'd16, "s2_count");
      wr(16'h6, 32'd1);
      rd(16'h6, 32'd16, "s2_count_17");
      for (int k = 0; k < 16; k++) begin
         exp_pair(16'h0200 + 16'(4 * k), 16'h0300 + 16'(4 * k),
                  {16'hD000, 16'h0200 + 16'(4 * k)});
      end
      wr(16'h0, 32'd1);
      wait_irq("s2", 200);
      wr(16'h1, 32'd0);
      hi = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.s_interrupt !== 1'b0) hi++;
         tick();
      end
      chk("s2_int_once", hi, 32'd0);

      // Multi-word, increment then fixed mode
      desc(16'h0200, 16'h0300, 16'd3);
      exp_pair(16'h0200, 16'h0300, 32'hD000_0200);
      exp_pair(16'h0204, 16'h0304, 32'hD000_0204);
      exp_pair(16'h0208, 16'h0308, 32'hD000_0208);
      wr(16'h0, 32'd1);
      wait_irq("s3_inc", 50);
      wr(16'h1, 32'd0);
      wr(16'h8, 32'd1);
      rd(16'h8, 32'd1, "s3_mode");
      desc(16'h0200, 16'h0300, 16'd3);
      for (int i = 0; i < 3; i++) begin
         exp_pair(16'h0200, 16'h0300, 32'hD000_0200);
      end
      wr(16'h0, 32'd1);
      wait_irq("s3_fix", 50);
      wr(16'h1, 32'd0);
      wr(16'h8, 32'd0);

      // Grant stall during READ
      bus.m_grant = 1'b0;
      desc(16'h0400, 16'h0500, 16'd1);
      exp_pair(16'h0400, 16'h0500, 32'hD000_0400);
      wr(16'h0, 32'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req", {31'b0, bus.m_req}, 32'd1);
         chk("stall_wr", {31'b0, bus.m_wr}, 32'd0);
         chk("stall_addr", {16'b0, bus.m_address}, 32'h0400);
         tick();
      end
      bus.m_grant = 1'b1;
      wait_irq("s4", 50);
      wr(16'h1, 32'd0);

      // Empty start; DONE set collides with a host clear
      wr(16'h0, 32'd1);
      tick();
      wr(16'h1, 32'd0);
      @(negedge clk);
      chk("s5_set_wins", {31'b0, bus.s_interrupt}, 32'd1);
      tick();
      wr(16'h1, 32'd0);
      @(negedge clk);
      chk("s5_clear", {31'b0, bus.s_interrupt}, 32'd0);
      tick();
      wr(16'h2, 32'd0);
      wr(16'h0, 32'd1);
      tick();
      tick();
      rd(16'h1, 32'd1, "s5_raw_irq");
      @(negedge clk);
      chk("s5_masked", {31'b0, bus.s_interrupt}, 32'd0);
      tick();
      wr(16'h2, 32'd1);
      @(negedge clk);
      chk("s5_unmask", {31'b0, bus.s_interrupt}, 32'd1);
      tick();
      wr(16'h1, 32'd0);

      // Reset while in WRITE
      desc(16'h0600, 16'h0700, 16'd2);
      desc(16'h0800, 16'h0900, 16'd1);
      bus_q.push_back('{wr: 1'b0, addr: 16'h0600, data: 32'd0});
      wr(16'h0, 32'd1);
      tick();
      tick();
      bus.m_grant = 1'b0;
      reset_n     = 1'b1;
      @(negedge clk);
      chk("s6_in_write", {31'b0, bus.m_wr}, 32'd1);
      tick();
      reset_n = 1'b0;
      @(negedge clk);
      chk("s6_req", {31'b0, bus.m_req}, 32'd0);
      chk("s6_wr", {31'b0, bus.m_wr}, 32'd0);
      chk("s6_addr", {16'b0, bus.m_address}, 32'd0);
      chk("s6_dout", bus.m_dout, 32'd0);
      chk("s6_int", {31'b0, bus.s_interrupt}, 32'd0);
      tick();
      rd(16'h9, 32'h4, "s6_status");
      rd(16'h6, 32'd0, "s6_count");
      tick();
      chk("end_bus_q", bus_q.size(), 32'd0);
      chk("end_rd_q", rd_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
